// File: rtl/vend_pkg.sv
// Shared definitions for the vending coin scheduler: coin codes, FSM states
// and the coin validity helper.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_05   = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK,
        ST_DISPENSE
    } state_t;

    // Only 0.5 and 1.0 coins reach the vending FSM; 00 and 11 are swallowed.
    function automatic logic coin_valid(input logic [1:0] code);
        return (code == COIN_05) || (code == COIN_10);
    endfunction

endpackage

// File: rtl/vend_coin_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr_i, wrapping modulo N. Supports N up to 8 (3-bit index).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [2:0]   grant_o,
    output logic         any_req_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   first_oh;
    logic [3:0]     offset;
    logic [3:0]     idx_sum;

    // Rotate requests so ptr_i sits at bit 0, isolate the lowest set bit,
    // then map the offset back to an absolute slot index.
    always_comb begin
        req_dbl  = {req_i, req_i} >> ptr_i;
        req_rot  = req_dbl[N-1:0];
        first_oh = req_rot & (-req_rot);
        offset   = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (first_oh[i]) begin
                offset = 4'(i);
            end
        end
        idx_sum = offset + {1'b0, ptr_i};
        if (idx_sum >= 4'(N)) begin
            idx_sum = idx_sum - 4'(N);
        end
        grant_o   = idx_sum[2:0];
        any_req_o = |req_i;
    end

endmodule

// File: rtl/vend_coin_sched.sv
// Coin scheduler in front of the vending FSM: round-robin shares the FSM's
// coin input among NUM_SLOTS acceptors, one coin in flight at a time, and
// stretches the FSM's sell/change result into DISP_CYCLES-long actuator pulses.
// Optional: define VEND_REJECT_CNT_EN to add an 8-bit saturating count of
// invalid coins (reject_cnt).
module vend_coin_sched #(
    parameter int NUM_SLOTS   = 4,
    parameter int DISP_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SLOTS-1:0]   slot_req,
    input  logic [2*NUM_SLOTS-1:0] slot_coin,
    output logic [NUM_SLOTS-1:0]   slot_ack,
    output logic [1:0]             coin_o,
    input  logic                   sell_i,
    input  logic                   change_i,
    output logic                   dispense_o,
    output logic                   change_o,
    output logic [2:0]             grant_id,
    output logic                   busy_o
`ifdef VEND_REJECT_CNT_EN
    ,
    output logic [7:0]             reject_cnt
`endif
);

    import vend_pkg::*;

    localparam int CNT_W = $clog2(DISP_CYCLES + 1);

    state_t               state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           code_q, code_d;
    logic [2:0]           gnt_q, gnt_d;
    logic                 chg_lat_q, chg_lat_d;
    logic [NUM_SLOTS-1:0] slot_ack_q, slot_ack_d;
    logic                 dispense_q, dispense_d;
    logic                 change_q, change_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;

    logic [2:0]           arb_grant;
    logic                 arb_any;
    logic [1:0]           arb_code;

    rr_arbiter #(.N(NUM_SLOTS)) u_arb (
        .req_i     (slot_req),
        .ptr_i     (rr_ptr_q),
        .grant_o   (arb_grant),
        .any_req_o (arb_any)
    );

    // Coin code of the slot the arbiter currently picks.
    always_comb begin
        arb_code = COIN_NONE;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (arb_grant == 3'(i)) begin
                arb_code = slot_coin[2*i +: 2];
            end
        end
    end

    // Next-state logic; registered outputs are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        gnt_d      = gnt_q;
        chg_lat_d  = chg_lat_q;
        grant_id_d = grant_id_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d      = arb_grant;
                    code_d     = arb_code;
                    grant_id_d = arb_grant;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rr_ptr_d = (gnt_q == 3'(NUM_SLOTS - 1)) ? 3'd0 : gnt_q + 3'd1;
                state_d  = coin_valid(code_q) ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                // change_i without sell_i is not a legal FSM response; ignored.
                if (sell_i) begin
                    cnt_d     = CNT_W'(DISP_CYCLES);
                    chg_lat_d = change_i;
                    state_d   = ST_DISPENSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_ack_d[i] = (state_d == ST_ISSUE) && (gnt_d == 3'(i));
        end
        dispense_d = (state_d == ST_DISPENSE);
        change_d   = (state_d == ST_DISPENSE) && chg_lat_d;
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 3'd0;
            cnt_q      <= '0;
            code_q     <= COIN_NONE;
            gnt_q      <= 3'd0;
            chg_lat_q  <= 1'b0;
            slot_ack_q <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            grant_id_q <= 3'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            gnt_q      <= gnt_d;
            chg_lat_q  <= chg_lat_d;
            slot_ack_q <= slot_ack_d;
            dispense_q <= dispense_d;
            change_q   <= change_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    // coin_o is the only decoded output: the coin must appear in the ack cycle.
    assign coin_o     = ((state_q == ST_ISSUE) && coin_valid(code_q)) ? code_q : COIN_NONE;
    assign slot_ack   = slot_ack_q;
    assign dispense_o = dispense_q;
    assign change_o   = change_q;
    assign grant_id   = grant_id_q;
    assign busy_o     = busy_q;

`ifdef VEND_REJECT_CNT_EN
    logic [7:0] rej_q, rej_d;

    // Count invalid coins as they are swallowed, saturating at 255.
    always_comb begin
        rej_d = rej_q;
        if ((state_q == ST_ISSUE) && !coin_valid(code_q) && (rej_q != 8'hFF)) begin
            rej_d = rej_q + 8'd1;
        end
    end

    // Reject counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= 8'd0;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_vend_coin_sched.sv
// Bench for vend_coin_sched: slot models, a scripted coin-FSM responder and
// scoreboard queues for acks, FSM responses and dispense pulses.
module tb_vend_coin_sched;

    typedef struct {
        int         slot;
        logic [1:0] coin;
    } ack_t;

    typedef struct {
        logic sell;
        logic chg;
    } resp_t;

    typedef struct {
        int   len;
        logic chg;
    } disp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] slot_req = 4'b0;
    logic [7:0] slot_coin;
    logic [3:0] slot_ack;
    logic [1:0] coin_o;
    logic       sell_i = 1'b0;
    logic       change_i = 1'b0;
    logic       dispense_o;
    logic       change_o;
    logic [2:0] grant_id;
    logic       busy_o;
`ifdef VEND_REJECT_CNT_EN
    logic [7:0] reject_cnt;
`endif

    logic [1:0] code [4];
    int         pend [4];
    ack_t       ack_q [$];
    resp_t      resp_q [$];
    disp_t      disp_q [$];

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    last_ack_cyc = -1;
    int    last_disp_cyc = -1;
    int    run_len = 0;
    bit    in_disp = 1'b0;
    bit    resp_underflow = 1'b0;
    disp_t cur_disp;
    ack_t  ea;
    logic [3:0] exp_ack;

    assign slot_coin = {code[3], code[2], code[1], code[0]};

    vend_coin_sched #(.NUM_SLOTS(4), .DISP_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .slot_req   (slot_req),
        .slot_coin  (slot_coin),
        .slot_ack   (slot_ack),
        .coin_o     (coin_o),
        .sell_i     (sell_i),
        .change_i   (change_i),
        .dispense_o (dispense_o),
        .change_o   (change_o),
        .grant_id   (grant_id),
        .busy_o     (busy_o)
`ifdef VEND_REJECT_CNT_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scripted coin FSM: registered sell/change one cycle after each coin.
    always @(posedge clk) begin
        if (coin_o !== 2'b00) begin
            if (resp_q.size() == 0) begin
                resp_underflow <= 1'b1;
                sell_i   <= 1'b0;
                change_i <= 1'b0;
            end else begin
                sell_i   <= resp_q[0].sell;
                change_i <= resp_q[0].chg;
                void'(resp_q.pop_front());
            end
        end else begin
            sell_i   <= 1'b0;
            change_i <= 1'b0;
        end
    end

    // Monitor: ack scoreboard, dispense pulse tracking, slot request model.
    always @(negedge clk) begin
        n_checks++;
        if (slot_ack !== 4'b0) begin
            if (ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: slot_ack=%b with nothing expected", slot_ack);
            end else begin
                ea = ack_q.pop_front();
                exp_ack = 4'(1 << ea.slot);
                if (slot_ack !== exp_ack || coin_o !== ea.coin || grant_id !== 3'(ea.slot)) begin
                    n_fail++;
                    $display("FAIL ack: slot_ack=%b coin_o=%b grant_id=%0d, expected %b %b %0d",
                             slot_ack, coin_o, grant_id, exp_ack, ea.coin, ea.slot);
                end
            end
            last_ack_cyc = cyc;
            for (int i = 0; i < 4; i++) begin
                if (slot_ack[i] && pend[i] > 0) pend[i]--;
            end
        end else if (coin_o !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_coin: coin_o=%b without ack, expected 00", coin_o);
        end

        n_checks++;
        if (change_i === 1'b1 && sell_i !== 1'b1) begin
            n_fail++;
            $display("FAIL fsm_resp: change_i=1 with sell_i=%b, expected sell_i=1", sell_i);
        end

        if (dispense_o === 1'b1) begin
            if (!in_disp) begin
                in_disp = 1'b1;
                run_len = 0;
                last_disp_cyc = cyc;
                n_checks++;
                if (disp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_dispense: dispense_o=1 with nothing expected");
                    cur_disp.len = 0;
                    cur_disp.chg = 1'b0;
                end else begin
                    cur_disp = disp_q.pop_front();
                end
            end
            run_len++;
            n_checks++;
            if (change_o !== cur_disp.chg) begin
                n_fail++;
                $display("FAIL change_level: change_o=%b, expected %b", change_o, cur_disp.chg);
            end
        end else begin
            n_checks++;
            if (change_o !== 1'b0) begin
                n_fail++;
                $display("FAIL change_idle: change_o=%b, expected 0", change_o);
            end
            if (in_disp) begin
                in_disp = 1'b0;
                n_checks++;
                if (run_len !== cur_disp.len) begin
                    n_fail++;
                    $display("FAIL dispense_len: %0d cycles, expected %0d", run_len, cur_disp.len);
                end
            end
        end

        for (int i = 0; i < 4; i++) slot_req[i] = (pend[i] > 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (ack_q.size() == 0 && resp_q.size() == 0 && disp_q.size() == 0 && !in_disp &&
                busy_o === 1'b0 && dispense_o === 1'b0 &&
                pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && pend[3] == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic coin(input int slot, input logic [1:0] c, input logic sell, input logic chg);
        ack_q.push_back('{slot, (c == 2'b01 || c == 2'b10) ? c : 2'b00});
        if (c == 2'b01 || c == 2'b10) resp_q.push_back('{sell, chg});
        if (sell) disp_q.push_back('{8, chg});
        code[slot] = c;
        pend[slot]++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (slot_ack !== 4'b0 || coin_o !== 2'b00 || dispense_o !== 1'b0 ||
            change_o !== 1'b0 || grant_id !== 3'd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b coin=%b disp=%b chg=%b gid=%0d busy=%b, expected all 0",
                     slot_ack, coin_o, dispense_o, change_o, grant_id, busy_o);
        end
`ifdef VEND_REJECT_CNT_EN
        n_checks++;
        if (reject_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_reject_cnt: %0d, expected 0", reject_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_slot();
        bit ok;
        coin(0, 2'b10, 1'b0, 1'b0);
        wait_quiet(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_first_timeout: not quiet, expected quiet"); end
        coin(0, 2'b10, 1'b1, 1'b0);
        wait_quiet(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_second_timeout: not quiet, expected quiet"); end
        n_checks++;
        if (last_disp_cyc - last_ack_cyc !== 2) begin
            n_fail++;
            $display("FAIL latency: ack->dispense %0d cycles, expected 2", last_disp_cyc - last_ack_cyc);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        rst = 1'b1;
        step();
        rst = 1'b0;
        coin(0, 2'b01, 1'b0, 1'b0);
        coin(1, 2'b01, 1'b0, 1'b0);
        coin(2, 2'b01, 1'b1, 1'b0);
        coin(3, 2'b01, 1'b0, 1'b0);
        coin(0, 2'b01, 1'b0, 1'b0);
        wait_quiet(150, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_timeout: not quiet, expected quiet"); end
    endtask

    task automatic test_change();
        bit ok;
        coin(1, 2'b01, 1'b0, 1'b0);
        wait_quiet(50, ok);
        coin(2, 2'b10, 1'b0, 1'b0);
        wait_quiet(50, ok);
        coin(2, 2'b10, 1'b1, 1'b1);
        wait_quiet(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL change_timeout: not quiet, expected quiet"); end
    endtask

    task automatic test_invalid();
        bit ok;
        int seen;
`ifdef VEND_REJECT_CNT_EN
        logic [7:0] rej_base;
        rej_base = reject_cnt;
`endif
        coin(2, 2'b11, 1'b0, 1'b0);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step();
            if (slot_ack !== 4'b0) seen = 1;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL invalid_ack_timeout: no ack, expected ack on slot 2");
        end else begin
            n_checks++;
            if (coin_o !== 2'b00) begin
                n_fail++;
                $display("FAIL invalid_coin_out: coin_o=%b, expected 00", coin_o);
            end
            step();
            n_checks++;
            if (busy_o !== 1'b0 || slot_ack !== 4'b0) begin
                n_fail++;
                $display("FAIL invalid_return: busy=%b ack=%b, expected 0 0000", busy_o, slot_ack);
            end
        end
        wait_quiet(50, ok);
`ifdef VEND_REJECT_CNT_EN
        n_checks++;
        if (reject_cnt !== rej_base + 8'd1) begin
            n_fail++;
            $display("FAIL reject_cnt_11: %0d, expected %0d", reject_cnt, rej_base + 8'd1);
        end
`endif
        coin(0, 2'b00, 1'b0, 1'b0);
        wait_quiet(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL invalid_timeout: not quiet, expected quiet"); end
`ifdef VEND_REJECT_CNT_EN
        n_checks++;
        if (reject_cnt !== rej_base + 8'd2) begin
            n_fail++;
            $display("FAIL reject_cnt_00: %0d, expected %0d", reject_cnt, rej_base + 8'd2);
        end
`endif
    endtask

    task automatic test_reset_in_dispense();
        bit ok;
        int seen;
        ack_q.push_back('{2, 2'b10});
        resp_q.push_back('{1'b1, 1'b0});
        disp_q.push_back('{4, 1'b0});
        code[2] = 2'b10;
        pend[2] = 1;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step();
            if (dispense_o === 1'b1) seen = 1;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL rstdisp_timeout: no dispense, expected dispense");
        end
        coin(1, 2'b01, 1'b0, 1'b0);
        coin(3, 2'b01, 1'b0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (slot_ack !== 4'b0 || coin_o !== 2'b00 || dispense_o !== 1'b0 ||
            change_o !== 1'b0 || grant_id !== 3'd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstdisp_outputs: ack=%b coin=%b disp=%b chg=%b gid=%0d busy=%b, expected all 0",
                     slot_ack, coin_o, dispense_o, change_o, grant_id, busy_o);
        end
        rst = 1'b0;
        wait_quiet(60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstdisp_quiet: not quiet, expected quiet"); end
    endtask

    task automatic test_req_during_dispense();
        bit ok;
        int seen;
        int idle_cyc;
        int ack_cyc;
        coin(0, 2'b10, 1'b1, 1'b0);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step();
            if (dispense_o === 1'b1) seen = 1;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL wait_timeout: no dispense, expected dispense");
        end
        coin(3, 2'b01, 1'b0, 1'b0);
        idle_cyc = -1;
        ack_cyc = -1;
        for (int k = 0; k < 30 && ack_cyc < 0; k++) begin
            step();
            if (dispense_o === 1'b1) begin
                n_checks++;
                if (slot_ack !== 4'b0) begin
                    n_fail++;
                    $display("FAIL ack_in_dispense: slot_ack=%b, expected 0000", slot_ack);
                end
            end
            if (busy_o === 1'b0 && idle_cyc < 0) idle_cyc = cyc;
            if (slot_ack !== 4'b0 && ack_cyc < 0) ack_cyc = cyc;
        end
        n_checks++;
        if (idle_cyc < 0 || ack_cyc !== idle_cyc + 1) begin
            n_fail++;
            $display("FAIL ack_after_idle: ack at %0d, idle at %0d, expected idle+1", ack_cyc, idle_cyc);
        end
        wait_quiet(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wait_quiet: not quiet, expected quiet"); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            code[i] = 2'b00;
            pend[i] = 0;
        end
        test_reset();
        test_single_slot();
        test_round_robin();
        test_change();
        test_invalid();
        test_reset_in_dispense();
        test_req_during_dispense();
        step();
        step();
        n_checks++;
        if (ack_q.size() != 0 || resp_q.size() != 0 || disp_q.size() != 0 || resp_underflow) begin
            n_fail++;
            $display("FAIL leftovers: acks=%0d resps=%0d disps=%0d underflow=%0d, expected 0 0 0 0",
                     ack_q.size(), resp_q.size(), disp_q.size(), resp_underflow);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
